ps2_host_tx: RTL and testbench

// - PS/2 host-to-device transmitter; counterpart of the keyboard receive path.
// - Sends command bytes to the keyboard (e.g. 0xED set-LEDs, 0xFF reset).
// - Bytes come from the PicoBlaze output port.
// - Drives open-drain PS2 clock/data through enable outputs; reports busy/done/error.

---
 rtl/ps2_host_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter.
// Sends one command byte per PicoBlaze write to PORT_TX.
// The PS/2 lines are open-drain: each *_OE output pulls its line low when it is 1.
//
// Ports:
//   CLK, RESET        system clock; asynchronous, active-low reset
//   Port_ID, Write_Strobe, Out_Port
//                     PicoBlaze output port; a write to PORT_TX starts a frame
//   PS2_Clock_In, PS2_Data_In
//                     sensed PS/2 lines (asynchronous)
//   PS2_Clock_OE, PS2_Data_OE
//                     1 = pull the line low
//   Tx_Busy           a frame is in progress
//   Tx_Done           sticky: the last frame was acknowledged
//   Tx_Error          sticky: the last frame was NACKed or timed out
//
// Optional build macro PS2_TX_STATUS_PORT_EN adds:
//   parameter PORT_STATUS
//   inputs    Read_Strobe
//   outputs   Status_Output, a registered status byte read at PORT_STATUS
module ps2_host_tx #(
  parameter logic [7:0]  PORT_TX        = 8'h08,
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000
`ifdef PS2_TX_STATUS_PORT_EN
  , parameter logic [7:0] PORT_STATUS   = 8'h09
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] Port_ID,
  input  logic       Write_Strobe,
  input  logic [7:0] Out_Port,
  input  logic       PS2_Clock_In,
  input  logic       PS2_Data_In,
  output logic       PS2_Clock_OE,
  output logic       PS2_Data_OE,
  output logic       Tx_Busy,
  output logic       Tx_Done,
  output logic       Tx_Error
`ifdef PS2_TX_STATUS_PORT_EN
  , input  logic       Read_Strobe
  , output logic [7:0] Status_Output
`endif
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic              parity_q, parity_d;
  logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]        edge_cnt_q, edge_cnt_d;
  logic              clock_oe_q, clock_oe_d;
  logic              data_oe_q, data_oe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Two-stage synchronisers, plus one extra clock stage for edge detection.
  // These reset to 1 (idle lines) so reset cannot create a false falling edge.
  logic clk_meta_q, clk_sync_q, clk_last_q;
  logic dat_meta_q, dat_sync_q;
  logic fall;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_last_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= PS2_Clock_In;
      clk_sync_q <= clk_meta_q;
      clk_last_q <= clk_sync_q;
      dat_meta_q <= PS2_Data_In;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign fall = clk_last_q & ~clk_sync_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    parity_d   = parity_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    edge_cnt_d = edge_cnt_q;
    clock_oe_d = clock_oe_q;
    data_oe_d  = data_oe_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (Write_Strobe && (Port_ID == PORT_TX)) begin
          data_d     = Out_Port;
          parity_d   = ~^Out_Port;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          clock_oe_d = 1'b1;
          // With a one-cycle inhibit, the first cycle is also the last one,
          // so the start bit must be driven immediately.
          data_oe_d  = (INHIBIT_CYCLES == 1);
          inh_cnt_d  = '0;
          state_d    = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // The outputs are registered, so the start bit is set one count
        // early. It then appears in the last inhibit cycle.
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 2)) data_oe_d = 1'b1;
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          clock_oe_d = 1'b0;
          to_cnt_d   = '0;
          edge_cnt_d = '0;
          state_d    = S_REQ;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin  // S_REQ .. S_ACK: device-clocked phase, under timeout
        if (fall) begin
          to_cnt_d   = '0;
          edge_cnt_d = edge_cnt_q + 4'd1;
          unique case (state_q)
            S_REQ, S_SHIFT: begin
              // edge_cnt_q counts the edges seen before this one, so it
              // is also the index of the data bit to put on the line.
              data_oe_d = ~data_q[edge_cnt_q[2:0]];
              state_d   = (edge_cnt_q == 4'd7) ? S_PARITY : S_SHIFT;
            end
            S_PARITY: begin
              data_oe_d = ~parity_q;
              state_d   = S_STOP;
            end
            S_STOP: begin
              data_oe_d = 1'b0;
              state_d   = S_ACK;
            end
            S_ACK: begin
              if (dat_sync_q) err_d  = 1'b1;
              else            done_d = 1'b1;
              state_d = S_WAIT_IDLE;
            end
            default: ;
          endcase
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d      = 1'b1;
          busy_d     = 1'b0;
          clock_oe_d = 1'b0;
          data_oe_d  = 1'b0;
          state_d    = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      parity_q   <= 1'b0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      edge_cnt_q <= '0;
      clock_oe_q <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      clock_oe_q <= clock_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign PS2_Clock_OE = clock_oe_q;
  assign PS2_Data_OE  = data_oe_q;
  assign Tx_Busy      = busy_q;
  assign Tx_Done      = done_q;
  assign Tx_Error     = err_q;

`ifdef PS2_TX_STATUS_PORT_EN
  logic [7:0] status_q, status_d;
  // Reading status has no side effects, so the read strobe is not needed.
  logic       unused_read_strobe;

  assign unused_read_strobe = Read_Strobe;

  always_comb begin
    status_d = '0;
    if (Port_ID == PORT_STATUS) status_d = {5'b0, err_q, done_q, busy_q};
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) status_q <= '0;
    else        status_q <= status_d;
  end

  assign Status_Output = status_q;
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  localparam int unsigned INH = 40;
  localparam int unsigned TO  = 2000;
  localparam int unsigned H   = 15;   // device clock half period in CLK cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] port_id = '0;
  logic [7:0] out_port = '0;
  logic       wr = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;
  logic       clock_oe, data_oe, busy, done, err;
`ifdef PS2_TX_STATUS_PORT_EN
  logic       rd = 1'b0;
  logic [7:0] status;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Wired-AND open-drain lines.
  assign ps2_clk_in = dev_clk  & ~clock_oe;
  assign ps2_dat_in = dev_data & ~data_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(clk), .RESET(rst_n), .Port_ID(port_id), .Write_Strobe(wr),
    .Out_Port(out_port), .PS2_Clock_In(ps2_clk_in), .PS2_Data_In(ps2_dat_in),
    .PS2_Clock_OE(clock_oe), .PS2_Data_OE(data_oe), .Tx_Busy(busy),
    .Tx_Done(done), .Tx_Error(err)
`ifdef PS2_TX_STATUS_PORT_EN
    , .Read_Strobe(rd), .Status_Output(status)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [7:0] pid, input logic [7:0] d);
    port_id = pid; out_port = d; wr = 1'b1;
    tick();
    wr = 1'b0; port_id = '0;
  endtask

  // Expected line bits as the device sees them: 8 data bits LSB first,
  // then odd parity and the stop bit.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = b[i];
    f[8] = ($countones(b) % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // Device model. It measures the inhibit, then clocks up to 11 pulses and
  // samples the data line on each rising edge. It optionally pulls data low
  // for the ack. A nonzero stop_fall makes it return right after that
  // falling edge, leaving the clock low.
  task automatic dev_frame(input int stop_fall, input bit do_ack, output logic [9:0] rx);
    int cnt = 0;
    int first = -1;
    rx = '0;
    while (clock_oe === 1'b1 && cnt < int'(INH) + 100) begin
      if (data_oe === 1'b1 && first < 0) first = cnt;
      cnt++;
      tick();
    end
    check("inhibit_len", cnt, INH);
    check("start_bit_cycle", first, INH - 1);
    check("start_bit_req", data_oe, 1);
    tick(20);
    for (int p = 1; p <= 11; p++) begin
      dev_clk = 1'b0;
      if (p == stop_fall) return;
      tick(H);
      dev_clk = 1'b1;
      if (p <= 10) rx[p-1] = ps2_dat_in;
      if (p == 10 && do_ack) dev_data = 1'b0;
      tick(H);
      if (p == 11) dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy === 1'b1 && c < 300) begin tick(); c++; end
    check("busy_released", busy, 0);
  endtask

  initial begin
    logic [9:0] rx;
    logic [7:0] b;
    bit         ack;
    int         k;

    tick(3);
    check("rst_clock_oe", clock_oe, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
`ifdef PS2_TX_STATUS_PORT_EN
    check("rst_status", status, 8'h00);
`endif
    rst_n = 1'b1;
    tick(2);

    write(8'h07, 8'h55);
    tick(3);
    check("wrong_port_ignored", busy, 0);

    // Acknowledged 0xED frame.
    write(8'h08, 8'hED);
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    check("start_err", err, 0);
    dev_frame(0, 1'b1, rx);
    check("frame_ED_ack", rx, exp_frame(8'hED));
    wait_idle();
    check("ack_done", done, 1);
    check("ack_err", err, 0);
`ifdef PS2_TX_STATUS_PORT_EN
    port_id = 8'h09; tick(); check("status_after_ack", status, 8'h02); port_id = '0;
`endif

    // NACK: the device never pulls data low.
    write(8'h08, 8'hED);
    dev_frame(0, 1'b0, rx);
    check("frame_ED_nack", rx, exp_frame(8'hED));
    wait_idle();
    check("nack_err", err, 1);
    check("nack_done", done, 0);
`ifdef PS2_TX_STATUS_PORT_EN
    port_id = 8'h09; tick(); check("status_after_nack", status, 8'h04); port_id = '0;
`endif

    // Timeout: no device clock at all.
    write(8'h08, 8'hFF);
    k = 0;
    while (clock_oe === 1'b1 && k < int'(INH) + 100) begin tick(); k++; end
    check("to_start_bit", data_oe, 1);
    k = 0;
    while (err !== 1'b1 && k < int'(TO) + 100) begin tick(); k++; end
    check("timeout_cycles", k, TO);
    check("to_clock_oe", clock_oe, 0);
    check("to_data_oe", data_oe, 0);
    check("to_busy", busy, 0);
    check("to_done", done, 0);

    // A write in mid-frame is ignored.
    write(8'h08, 8'hED);
    fork
      dev_frame(0, 1'b1, rx);
      begin
        tick(INH + 60);
        write(8'h08, 8'h00);
        check("midwrite_busy", busy, 1);
        check("midwrite_done", done, 0);
        check("midwrite_err", err, 0);
`ifdef PS2_TX_STATUS_PORT_EN
        port_id = 8'h09; tick(); check("status_in_frame", status, 8'h01); port_id = '0;
`endif
      end
    join
    check("frame_ED_midwrite", rx, exp_frame(8'hED));
    wait_idle();
    check("midwrite_final_done", done, 1);

    // Reset after falling edge 5.
    write(8'h08, 8'hED);
    dev_frame(5, 1'b1, rx);
    tick(6);
    check("pre_reset_data_oe", data_oe, 1);
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_clock_oe", clock_oe, 0);
    check("midrst_data_oe", data_oe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    dev_clk = 1'b1; dev_data = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    write(8'h08, 8'hED);
    dev_frame(0, 1'b1, rx);
    check("frame_after_reset", rx, exp_frame(8'hED));
    wait_idle();
    check("after_reset_done", done, 1);

    // Random bytes with random ack/nack.
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      write(8'h08, b);
      dev_frame(0, ack, rx);
      check("rand_frame", rx, exp_frame(b));
      wait_idle();
      check("rand_done", done, ack);
      check("rand_err", err, !ack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
